mux2_rr_sel_gen: RTL and testbench

- Sequential select generator that sits directly upstream of the team's 2:1 mux (in0/in1/sel → out).
- Arbitrates two requesters using a round-robin policy with a programmable burst length. Drives a registered `sel` and the matching registered data word.
- Presents the result on a 1-entry valid/ready output stage, so the mux output feeds a downstream consumer with backpressure.

---
 rtl/mux2_rr_sel_gen.sv | 106 ++++++++++
 tb/tb_mux2_rr_sel_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_sel_gen.sv
// Round-robin select generator feeding a 2:1 mux through a 1-entry valid/ready stage.
// Optional grant counters: define MUX2_RR_GRANT_CNT_EN.
module mux2_rr_sel_gen #(
  parameter int DW    = 1,
  parameter int BURST = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] in0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DW-1:0] in1,
  output logic          ack1,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
`ifdef MUX2_RR_GRANT_CNT_EN
  ,
  output logic [7:0]    gnt_cnt0,
  output logic [7:0]    gnt_cnt1
`endif
);

  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] bcnt_q, bcnt_d;

  logic load_ok;
  logic grant;
  logic w;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

  assign load_ok = !out_valid | out_ready;
  assign grant   = rst_n & load_ok & (req0 | req1);
  assign w       = (req0 & req1) ? prio_q : req1;
  assign ack0    = grant & ~w;
  assign ack1    = grant & w;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    prio_d  = prio_q;
    bcnt_d  = bcnt_q;
    if (grant) begin
      state_d = FULL;
      sel_d   = w;
      data_d  = w ? in1 : in0;
      // Favoured side keeps priority until it has used its burst.
      if (w == prio_q && bcnt_q != CW'(BURST - 1)) begin
        bcnt_d = bcnt_q + 1'b1;
      end else begin
        prio_d = ~w;
        bcnt_d = '0;
      end
    end else if (out_valid && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      sel_q   <= 1'b0;
      data_q  <= '0;
      prio_q  <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      prio_q  <= prio_d;
      bcnt_q  <= bcnt_d;
    end
  end

`ifdef MUX2_RR_GRANT_CNT_EN
  logic [7:0] gc0_q, gc1_q;

  assign gnt_cnt0 = gc0_q;
  assign gnt_cnt1 = gc1_q;

  // Saturating counters; no wrap past 255.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gc0_q <= '0;
      gc1_q <= '0;
    end else begin
      if (ack0 && gc0_q != 8'hFF) gc0_q <= gc0_q + 8'd1;
      if (ack1 && gc1_q != 8'hFF) gc1_q <= gc1_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_sel_gen.sv
// Directed bench for mux2_rr_sel_gen; checks BURST=1 (a) and BURST=2 (b) side by side.
module tb_mux2_rr_sel_gen;

  logic clk = 1'b0;
  logic rst_n, req0, req1, out_ready;
  logic [0:0] in0, in1;

  logic ack0_a, ack1_a, sel_a, ov_a;
  logic [0:0] od_a;
  logic ack0_b, ack1_b, sel_b, ov_b;
  logic [0:0] od_b;
`ifdef MUX2_RR_GRANT_CNT_EN
  logic [7:0] gc0_a, gc1_a, gc0_b, gc1_b;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] win_a, win_b;

  always #5 clk = ~clk;

  mux2_rr_sel_gen #(.DW(1), .BURST(1)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .in0(in0), .ack0(ack0_a),
    .req1(req1), .in1(in1), .ack1(ack1_a),
    .sel(sel_a), .out_valid(ov_a), .out_data(od_a),
    .out_ready(out_ready)
`ifdef MUX2_RR_GRANT_CNT_EN
    , .gnt_cnt0(gc0_a), .gnt_cnt1(gc1_a)
`endif
  );

  mux2_rr_sel_gen #(.DW(1), .BURST(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .in0(in0), .ack0(ack0_b),
    .req1(req1), .in1(in1), .ack1(ack1_b),
    .sel(sel_b), .out_valid(ov_b), .out_data(od_b),
    .out_ready(out_ready)
`ifdef MUX2_RR_GRANT_CNT_EN
    , .gnt_cnt0(gc0_b), .gnt_cnt1(gc1_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    in0 = 1'b1; in1 = 1'b0; out_ready = 1'b1;
    win_a = 6'b101010;
    win_b = 6'b001100;

    // 1: reset held 3 edges with both requesting
    @(negedge clk);
    #1;
    chk("rst_ack0", {31'd0, ack0_a}, 0);
    chk("rst_ack1", {31'd0, ack1_a}, 0);
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, ov_a}, 0);
    chk("rst_sel", {31'd0, sel_a}, 0);
    chk("rst_data", {31'd0, od_a}, 0);
    chk("rst_valid_b", {31'd0, ov_b}, 0);
    rst_n = 1'b1;
    #1;
    chk("first_ack0", {31'd0, ack0_a}, 1);
    chk("first_ack1", {31'd0, ack1_a}, 0);
    chk("first_ack0_b", {31'd0, ack0_b}, 1);

    // 2: single requester, full throughput
    do_reset();
    req0 = 1'b1; in0 = 1'b1; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("single_ack0_%0d", i), {31'd0, ack0_a}, 1);
      chk($sformatf("single_ack1_%0d", i), {31'd0, ack1_a}, 0);
      tick();
      chk($sformatf("single_sel_%0d", i), {31'd0, sel_a}, 0);
      chk($sformatf("single_data_%0d", i), {31'd0, od_a}, 1);
      chk($sformatf("single_valid_%0d", i), {31'd0, ov_a}, 1);
    end

    // 3/4: contention, BURST=1 and BURST=2
    do_reset();
    req0 = 1'b1; req1 = 1'b1; in0 = 1'b1; in1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr1_ack0_%0d", i), {31'd0, ack0_a}, {31'd0, ~win_a[i]});
      chk($sformatf("rr1_ack1_%0d", i), {31'd0, ack1_a}, {31'd0, win_a[i]});
      chk($sformatf("rr2_ack0_%0d", i), {31'd0, ack0_b}, {31'd0, ~win_b[i]});
      chk($sformatf("rr2_ack1_%0d", i), {31'd0, ack1_b}, {31'd0, win_b[i]});
      tick();
      chk($sformatf("rr1_sel_%0d", i), {31'd0, sel_a}, {31'd0, win_a[i]});
      chk($sformatf("rr1_data_%0d", i), {31'd0, od_a}, {31'd0, ~win_a[i]});
      chk($sformatf("rr2_sel_%0d", i), {31'd0, sel_b}, {31'd0, win_b[i]});
      chk($sformatf("rr2_data_%0d", i), {31'd0, od_b}, {31'd0, ~win_b[i]});
    end
`ifdef MUX2_RR_GRANT_CNT_EN
    chk("gcnt0_a", {24'd0, gc0_a}, 3);
    chk("gcnt1_a", {24'd0, gc1_a}, 3);
    chk("gcnt0_b", {24'd0, gc0_b}, 4);
    chk("gcnt1_b", {24'd0, gc1_b}, 2);
`endif

    // 5: backpressure
    do_reset();
    req0 = 1'b1; in0 = 1'b1; req1 = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_load_data", {31'd0, od_a}, 1);
    req0 = 1'b0; req1 = 1'b1; in1 = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_ack1_%0d", i), {31'd0, ack1_a}, 0);
      tick();
      chk($sformatf("bp_data_%0d", i), {31'd0, od_a}, 1);
      chk($sformatf("bp_sel_%0d", i), {31'd0, sel_a}, 0);
      chk($sformatf("bp_valid_%0d", i), {31'd0, ov_a}, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ack1", {31'd0, ack1_a}, 1);
    tick();
    chk("bp_release_data", {31'd0, od_a}, 0);
    chk("bp_release_sel", {31'd0, sel_a}, 1);
    req1 = 1'b0;
    #1;
    chk("drain_ack1", {31'd0, ack1_a}, 0);
    tick();
    chk("drain_valid", {31'd0, ov_a}, 0);
    chk("drain_sel", {31'd0, sel_a}, 1);
    chk("drain_data", {31'd0, od_a}, 0);

    // 6: reset mid-operation
    do_reset();
    req0 = 1'b1; req1 = 1'b1; in0 = 1'b1; in1 = 1'b0;
    tick();
    chk("mid_data", {31'd0, od_a}, 1);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack0", {31'd0, ack0_a}, 0);
    tick();
    rst_n = 1'b1;
    chk("mid_valid", {31'd0, ov_a}, 0);
    chk("mid_data_clr", {31'd0, od_a}, 0);
`ifdef MUX2_RR_GRANT_CNT_EN
    chk("mid_gcnt0", {24'd0, gc0_a}, 0);
    chk("mid_gcnt1", {24'd0, gc1_a}, 0);
`endif
    out_ready = 1'b1;
    #1;
    chk("mid_ack0", {31'd0, ack0_a}, 1);
    chk("mid_ack1", {31'd0, ack1_a}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
